// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the select-control slice: defaults, step encoding
// and the helper functions used by the top level.
package mux_ctrl_pkg;

  localparam int unsigned SEL_W_DEF   = 2;
  localparam int unsigned SEL_RST_DEF = 0;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_e;

  // Manual events beat the scan tick; opposing presses cancel each other.
  function automatic step_e step_select(input logic up_ev, input logic dn_ev, input logic tick);
    step_e step;
    if (up_ev && dn_ev) begin
      step = STEP_HOLD;
    end else if (up_ev) begin
      step = STEP_INC;
    end else if (dn_ev) begin
      step = STEP_DEC;
    end else if (tick) begin
      step = STEP_INC;
    end else begin
      step = STEP_HOLD;
    end
    return step;
  endfunction

  function automatic logic onehot_bit(input int unsigned sel_v, input int unsigned idx);
    return (sel_v == idx);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-level debounce
// and a registered one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned     CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stb;
  logic             r_stb_q;
  logic             r_rise;
  logic [CNT_W-1:0] r_dcnt;

  // Synchroniser, stable-level tracking and press-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_stb   <= 1'b0;
      r_stb_q <= 1'b0;
      r_rise  <= 1'b0;
      r_dcnt  <= {CNT_W{1'b0}};
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_stb_q <= r_stb;
      r_rise  <= r_stb & ~r_stb_q;
      if (r_s2 == r_stb) begin
        r_dcnt <= {CNT_W{1'b0}};
      end else if (r_dcnt == CNT_MAX) begin
        r_stb  <= r_s2;
        r_dcnt <= {CNT_W{1'b0}};
      end else begin
        r_dcnt <= r_dcnt + CNT_W'(1'b1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/mux_sel_ctrl.sv
// Select-value controller for the 4-way keyed selector: debounced up/down
// buttons plus optional periodic auto-scan, with one-hot LED copy.
module mux_sel_ctrl
  import mux_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W       = SEL_W_DEF,
  parameter int unsigned DEB_CYCLES  = 1000,
  parameter int unsigned SCAN_CYCLES = 5000000,
  parameter int unsigned SEL_RST     = SEL_RST_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  auto_en,
  output logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   sel_onehot,
  output logic                  sel_chg
);

  localparam int unsigned      SCAN_W   = $clog2(SCAN_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);

  logic              w_up_ev;
  logic              w_dn_ev;
  logic              w_manual;
  logic              w_tick;
  step_e             w_step;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [SCAN_W-1:0] w_scan_nxt;

  logic [SEL_W-1:0]  r_sel;
  logic              r_sel_chg;
  logic [SCAN_W-1:0] r_scan;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_up),
    .o_rise (w_up_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_down),
    .o_rise (w_dn_ev)
  );

  assign w_manual = w_up_ev | w_dn_ev;
  assign w_tick   = auto_en & (r_scan == SCAN_MAX);

  // Next select value and scan count; any manual event restarts the scan period.
  always_comb begin
    w_step     = step_select(w_up_ev, w_dn_ev, w_tick);
    w_sel_nxt  = r_sel;
    w_scan_nxt = r_scan;
    case (w_step)
      STEP_INC:  w_sel_nxt = r_sel + SEL_W'(1'b1);
      STEP_DEC:  w_sel_nxt = r_sel - SEL_W'(1'b1);
      STEP_HOLD: w_sel_nxt = r_sel;
      default:   w_sel_nxt = r_sel;
    endcase
    if (!auto_en || w_manual) begin
      w_scan_nxt = {SCAN_W{1'b0}};
    end else if (r_scan == SCAN_MAX) begin
      w_scan_nxt = {SCAN_W{1'b0}};
    end else begin
      w_scan_nxt = r_scan + SCAN_W'(1'b1);
    end
  end

  // Select, change-pulse and scan-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= SEL_W'(SEL_RST);
      r_sel_chg <= 1'b0;
      r_scan    <= {SCAN_W{1'b0}};
    end else begin
      r_sel     <= w_sel_nxt;
      r_sel_chg <= (w_sel_nxt != r_sel);
      r_scan    <= w_scan_nxt;
    end
  end

  assign sel     = r_sel;
  assign sel_chg = r_sel_chg;

  for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_onehot
    assign sel_onehot[gi] = onehot_bit(32'(r_sel), 32'(gi));
  end

endmodule
